lora_rx_sequencer: RTL and testbench

Receive-side companion to the LoRa transmit sequencer for the SX1278. It configures the radio for continuous receive and polls RegIrqFlags for RxDone. On each good packet it reads the length and FIFO pointer, then streams the payload bytes out over a valid/ready port. All radio access goes through a single-outstanding SPI transaction handshake toward the existing SPI controller, using the {wr, addr[6:0]} address-byte format.

---
 rtl/lora_rx_sequencer.sv | 178 +++++++++++++++++
 tb/tb_lora_rx_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lora_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module : lora_rx_sequencer
// Brief  : SX1278 continuous-receive sequencer; polls RxDone, streams payload.
// Rev    : 1.0
// ============================================================================
module lora_rx_sequencer #(
    parameter int POLL_DIV = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    output logic       o_spi_req,
    output logic [7:0] o_spi_addr,
    output logic [7:0] o_spi_wdata,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rdata,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_last,
    input  logic       i_rx_ready,
    output logic [7:0] o_pkt_len,
    output logic       o_crc_err,
    output logic       o_busy,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        STDBY   = 4'd1,
        RXBASE  = 4'd2,
        RXCONT  = 4'd3,
        WAIT    = 4'd4,
        RD_IRQ  = 4'd5,
        CLR_IRQ = 4'd6,
        RD_LEN  = 4'd7,
        RD_CUR  = 4'd8,
        SET_PTR = 4'd9,
        RD_FIFO = 4'd10,
        PRESENT = 4'd11,
        STOP    = 4'd12
    } state_t;

    localparam logic [15:0] c_poll_last = 16'(POLL_DIV - 1);

    state_t      r_state;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_flags;
    logic [7:0]  r_cur_ptr;
    logic [7:0]  r_idx;

    logic        w_txn;
    logic [7:0]  w_addr;
    logic [7:0]  w_wdata;

    // Register access issued by each transaction state
    always_comb begin
        w_txn   = 1'b1;
        w_addr  = 8'h00;
        w_wdata = 8'h00;
        case (r_state)
            STDBY, STOP: begin w_addr = 8'h81; w_wdata = 8'h81; end
            RXBASE:      begin w_addr = 8'h8F; w_wdata = 8'h00; end
            RXCONT:      begin w_addr = 8'h81; w_wdata = 8'h85; end
            RD_IRQ:      w_addr = 8'h12;
            CLR_IRQ:     begin w_addr = 8'h92; w_wdata = r_flags; end
            RD_LEN:      w_addr = 8'h13;
            RD_CUR:      w_addr = 8'h10;
            SET_PTR:     begin w_addr = 8'h8D; w_wdata = r_cur_ptr; end
            RD_FIFO:     w_addr = 8'h00;
            default:     w_txn = 1'b0;
        endcase
    end

    assign o_busy  = (r_state != IDLE);
    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_poll_cnt  <= '0;
            r_flags     <= '0;
            r_cur_ptr   <= '0;
            r_idx       <= '0;
            o_spi_req   <= 1'b0;
            o_spi_addr  <= '0;
            o_spi_wdata <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_data   <= '0;
            o_rx_last   <= 1'b0;
            o_pkt_len   <= '0;
            o_crc_err   <= 1'b0;
        end else begin
            o_crc_err <= 1'b0;
            if (r_state != WAIT) begin
                r_poll_cnt <= '0;
            end

            // Request rises one cycle after entering a state; the state only
            // advances on done, so req is always low for a cycle in between.
            if (w_txn && !o_spi_req) begin
                o_spi_req   <= 1'b1;
                o_spi_addr  <= w_addr;
                o_spi_wdata <= w_wdata;
            end else if (o_spi_req && i_spi_done) begin
                o_spi_req <= 1'b0;
                case (r_state)
                    STDBY:   r_state <= RXBASE;
                    RXBASE:  r_state <= RXCONT;
                    RXCONT:  r_state <= WAIT;
                    RD_IRQ: begin
                        r_flags <= i_spi_rdata;
                        r_state <= i_spi_rdata[6] ? CLR_IRQ : WAIT;
                    end
                    CLR_IRQ: begin
                        if (r_flags[5]) begin
                            o_crc_err <= 1'b1;
                            r_state   <= WAIT;
                        end else begin
                            r_idx   <= '0;
                            r_state <= RD_LEN;
                        end
                    end
                    RD_LEN: begin
                        o_pkt_len <= i_spi_rdata;
                        r_state   <= (i_spi_rdata == 8'h00) ? WAIT : RD_CUR;
                    end
                    RD_CUR: begin
                        r_cur_ptr <= i_spi_rdata;
                        r_state   <= SET_PTR;
                    end
                    SET_PTR: r_state <= RD_FIFO;
                    RD_FIFO: begin
                        o_rx_data  <= i_spi_rdata;
                        o_rx_valid <= 1'b1;
                        o_rx_last  <= (r_idx == (o_pkt_len - 8'd1));
                        r_state    <= PRESENT;
                    end
                    STOP:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (i_enable) begin
                        r_state <= STDBY;
                    end
                end
                WAIT: begin
                    if (!i_enable) begin
                        r_state <= STOP;
                    end else if (r_poll_cnt == c_poll_last) begin
                        r_poll_cnt <= '0;
                        r_state    <= RD_IRQ;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                    end
                end
                PRESENT: begin
                    if (o_rx_valid && i_rx_ready) begin
                        o_rx_valid <= 1'b0;
                        o_rx_last  <= 1'b0;
                        if (o_rx_last) begin
                            r_state <= WAIT;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= RD_FIFO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lora_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_lora_rx_sequencer
// Brief  : Directed bench with an SX1278 register responder (done after 4 cycles).
// Rev    : 1.0
// ============================================================================
module tb_lora_rx_sequencer;
    localparam int POLL_DIV = 20;
    localparam int POLL_GAP = POLL_DIV + 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       spi_req;
    logic [7:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rdata = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_ready = 1'b1;
    logic [7:0] pkt_len;
    logic       crc_err;
    logic       busy;
    logic [3:0] state;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] log_addr[$];
    logic [7:0] log_wdata[$];
    int         log_cyc[$];
    logic [7:0] rx_q[$];
    logic       rx_last_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] irq_val = 8'h00;
    logic [7:0] len_val = 8'h00;
    logic [7:0] cur_val = 8'h00;

    logic       pending = 1'b0;
    logic       prev_req = 1'b0;
    logic       prev_crc = 1'b0;
    int         wait_cnt = 0;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] cur_wdata = 8'h00;
    int         gap_errs = 0;
    int         stable_errs = 0;
    int         crc_cnt = 0;
    int         crc_cyc = 0;
    int         crc_wide = 0;

    lora_rx_sequencer #(.POLL_DIV(POLL_DIV)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .o_spi_req  (spi_req),
        .o_spi_addr (spi_addr),
        .o_spi_wdata(spi_wdata),
        .i_spi_done (spi_done),
        .i_spi_rdata(spi_rdata),
        .o_rx_valid (rx_valid),
        .o_rx_data  (rx_data),
        .o_rx_last  (rx_last),
        .i_rx_ready (rx_ready),
        .o_pkt_len  (pkt_len),
        .o_crc_err  (crc_err),
        .o_busy     (busy),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    // One clock: radio model and monitors at negedge, return 1 after posedge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            pending  = 1'b0;
            spi_done = 1'b0;
            spi_rdata = 8'h00;
            prev_req = 1'b0;
        end else begin
            spi_done  = 1'b0;
            spi_rdata = 8'h5A;
            if (pending) begin
                if (spi_req !== 1'b1 || spi_addr !== cur_addr || spi_wdata !== cur_wdata)
                    stable_errs++;
                wait_cnt++;
                if (wait_cnt == 3) begin
                    pending  = 1'b0;
                    spi_done = 1'b1;
                    spi_rdata = 8'h00;
                    if (cur_addr == 8'h92) begin
                        irq_val = irq_val & ~cur_wdata;
                    end else if (!cur_addr[7]) begin
                        case (cur_addr[6:0])
                            7'h12: spi_rdata = irq_val;
                            7'h13: spi_rdata = len_val;
                            7'h10: spi_rdata = cur_val;
                            7'h00: spi_rdata = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hEE;
                            default: spi_rdata = 8'h00;
                        endcase
                    end
                end
            end else if (spi_req === 1'b1) begin
                if (prev_req) gap_errs++;
                pending   = 1'b1;
                wait_cnt  = 0;
                cur_addr  = spi_addr;
                cur_wdata = spi_wdata;
                log_addr.push_back(spi_addr);
                log_wdata.push_back(spi_wdata);
                log_cyc.push_back(cyc);
            end
            prev_req = spi_req;
            if (rx_valid && rx_ready) begin
                rx_q.push_back(rx_data);
                rx_last_q.push_back(rx_last);
            end
            if (crc_err) begin
                crc_cnt++;
                crc_cyc = cyc;
                if (prev_crc) crc_wide++;
            end
            prev_crc = crc_err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++;
        if ({spi_req, spi_addr, spi_wdata} !== 17'h0) begin
            bad++; $display("FAIL reset_spi: got req=%b addr=%h wdata=%h required all 0", spi_req, spi_addr, spi_wdata);
        end
        total++;
        if ({rx_valid, rx_data, rx_last, crc_err} !== 11'h0) begin
            bad++; $display("FAIL reset_rx: got valid=%b data=%h last=%b crc=%b required all 0", rx_valid, rx_data, rx_last, crc_err);
        end
        total++;
        if ({pkt_len, busy, state} !== 13'h0) begin
            bad++; $display("FAIL reset_status: got len=%h busy=%b state=%0d required all 0", pkt_len, busy, state);
        end
    endtask

    task automatic test_config();
        enable = 1'b1;
        for (int n = 0; n < 400 && log_addr.size() < 5; n++) tick();
        total++;
        if (log_addr.size() < 5) begin
            bad++; $display("FAIL config_timeout: got %0d txns required >=5", log_addr.size());
        end else begin
            total++;
            if ({log_addr[0], log_wdata[0]} !== 16'h8181) begin
                bad++; $display("FAIL config_stdby: got %h/%h required 81/81", log_addr[0], log_wdata[0]);
            end
            total++;
            if ({log_addr[1], log_wdata[1]} !== 16'h8F00) begin
                bad++; $display("FAIL config_rxbase: got %h/%h required 8f/00", log_addr[1], log_wdata[1]);
            end
            total++;
            if ({log_addr[2], log_wdata[2]} !== 16'h8185) begin
                bad++; $display("FAIL config_rxcont: got %h/%h required 81/85", log_addr[2], log_wdata[2]);
            end
            total++;
            if ({log_addr[3], log_wdata[3], log_addr[4], log_wdata[4]} !== 32'h12001200) begin
                bad++; $display("FAIL config_poll: got %h/%h %h/%h required 12/00 12/00", log_addr[3], log_wdata[3], log_addr[4], log_wdata[4]);
            end
            total++;
            if (log_cyc[3] - log_cyc[2] != POLL_GAP || log_cyc[4] - log_cyc[3] != POLL_GAP) begin
                bad++; $display("FAIL poll_interval: got %0d,%0d required %0d", log_cyc[3] - log_cyc[2], log_cyc[4] - log_cyc[3], POLL_GAP);
            end
        end
    endtask

    task automatic test_packet();
        int s;
        int k;
        s = log_addr.size();
        k = -1;
        rx_q.delete(); rx_last_q.delete();
        len_val = 8'd3; cur_val = 8'h10;
        fifo_q = '{8'hA1, 8'hB2, 8'hC3};
        irq_val = 8'h40;
        for (int n = 0; n < 600 && rx_q.size() < 3; n++) tick();
        repeat (5) tick();
        total++;
        if (rx_q.size() != 3) begin
            bad++; $display("FAIL pkt_count: got %0d bytes required 3", rx_q.size());
        end else begin
            total++;
            if ({rx_q[0], rx_q[1], rx_q[2]} !== 24'hA1B2C3) begin
                bad++; $display("FAIL pkt_data: got %h %h %h required a1 b2 c3", rx_q[0], rx_q[1], rx_q[2]);
            end
            total++;
            if ({rx_last_q[0], rx_last_q[1], rx_last_q[2]} !== 3'b001) begin
                bad++; $display("FAIL pkt_last: got %b%b%b required 001", rx_last_q[0], rx_last_q[1], rx_last_q[2]);
            end
        end
        total++;
        if (pkt_len !== 8'd3) begin
            bad++; $display("FAIL pkt_len: got %0d required 3", pkt_len);
        end
        for (int i = s; i < log_addr.size(); i++) if (k < 0 && log_addr[i] == 8'h92) k = i;
        total++;
        if (k < 0 || k + 6 >= log_addr.size()) begin
            bad++; $display("FAIL pkt_seq_len: clear write at %0d of %0d txns required 7 txns from it", k, log_addr.size());
        end else if ({log_wdata[k], log_addr[k+1], log_addr[k+2], log_addr[k+3], log_wdata[k+3],
                      log_addr[k+4], log_addr[k+5], log_addr[k+6]} !== 64'h40_13_10_8D_10_00_00_00) begin
            bad++; $display("FAIL pkt_seq: got 92/%h %h %h %h/%h %h %h %h required 92/40 13 10 8d/10 00 00 00",
                            log_wdata[k], log_addr[k+1], log_addr[k+2], log_addr[k+3], log_wdata[k+3],
                            log_addr[k+4], log_addr[k+5], log_addr[k+6]);
        end
    endtask

    task automatic test_crc();
        int s;
        int k;
        int c0;
        int r0;
        s = log_addr.size();
        k = -1;
        c0 = crc_cnt;
        r0 = rx_q.size();
        irq_val = 8'h60;
        repeat (120) tick();
        total++;
        if (crc_cnt - c0 != 1 || crc_wide != 0) begin
            bad++; $display("FAIL crc_pulse: got %0d pulses wide=%0d required 1 single-cycle", crc_cnt - c0, crc_wide);
        end
        for (int i = s; i < log_addr.size(); i++) if (k < 0 && log_addr[i] == 8'h92) k = i;
        total++;
        if (k < 0 || k + 1 >= log_addr.size()) begin
            bad++; $display("FAIL crc_seq_len: clear write at %0d of %0d txns", k, log_addr.size());
        end else begin
            total++;
            if ({log_wdata[k], log_addr[k+1]} !== 16'h6012) begin
                bad++; $display("FAIL crc_seq: got 92/%h then %h required 92/60 then 12", log_wdata[k], log_addr[k+1]);
            end
            total++;
            if (log_cyc[k+1] - log_cyc[k] != POLL_GAP) begin
                bad++; $display("FAIL crc_repoll: got %0d cycles required %0d", log_cyc[k+1] - log_cyc[k], POLL_GAP);
            end
            total++;
            if (crc_cyc != log_cyc[k] + 4) begin
                bad++; $display("FAIL crc_timing: got cycle %0d required %0d", crc_cyc, log_cyc[k] + 4);
            end
        end
        total++;
        if (rx_q.size() != r0) begin
            bad++; $display("FAIL crc_no_data: got %0d bytes required %0d", rx_q.size(), r0);
        end
    endtask

    task automatic test_zero_len();
        int s;
        int k;
        int r0;
        s = log_addr.size();
        k = -1;
        r0 = rx_q.size();
        len_val = 8'd0;
        irq_val = 8'h40;
        repeat (120) tick();
        for (int i = s; i < log_addr.size(); i++) if (k < 0 && log_addr[i] == 8'h13) k = i;
        total++;
        if (k < 0 || k + 1 >= log_addr.size()) begin
            bad++; $display("FAIL zlen_seq_len: length read at %0d of %0d txns", k, log_addr.size());
        end else if (log_addr[k+1] !== 8'h12 || log_cyc[k+1] - log_cyc[k] != POLL_GAP) begin
            bad++; $display("FAIL zlen_repoll: got %h after %0d cycles required 12 after %0d", log_addr[k+1], log_cyc[k+1] - log_cyc[k], POLL_GAP);
        end
        total++;
        if (rx_q.size() != r0 || pkt_len !== 8'd0) begin
            bad++; $display("FAIL zlen_no_data: got %0d bytes len=%0d required 0 bytes len=0", rx_q.size() - r0, pkt_len);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        logic stable;
        rx_q.delete(); rx_last_q.delete();
        rx_ready = 1'b0;
        len_val = 8'd2; cur_val = 8'h20;
        fifo_q = '{8'h11, 8'h22};
        irq_val = 8'h40;
        for (int n = 0; n < 300 && !rx_valid; n++) tick();
        n0 = log_addr.size();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_valid !== 1'b1 || rx_data !== 8'h11) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++; $display("FAIL bp_hold: got valid=%b data=%h required 1/11 for 20 cycles", rx_valid, rx_data);
        end
        total++;
        if (log_addr.size() != n0) begin
            bad++; $display("FAIL bp_no_read: got %0d new txns required 0", log_addr.size() - n0);
        end
        rx_ready = 1'b1;
        tick();
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drop: got valid=%b after accept required 0", rx_valid);
        end
        for (int n = 0; n < 300 && rx_q.size() < 2; n++) tick();
        total++;
        if (rx_q.size() != 2) begin
            bad++; $display("FAIL bp_count: got %0d bytes required 2", rx_q.size());
        end else if ({rx_q[0], rx_q[1], rx_last_q[0], rx_last_q[1]} !== 18'b00010001_00100010_01) begin
            bad++; $display("FAIL bp_data: got %h/%b %h/%b required 11/0 22/1", rx_q[0], rx_last_q[0], rx_q[1], rx_last_q[1]);
        end
    endtask

    task automatic test_len255();
        int data_errs;
        int last_cnt;
        rx_q.delete(); rx_last_q.delete();
        for (int i = 0; i < 255; i++) fifo_q.push_back(8'(i));
        len_val = 8'd255; cur_val = 8'h00;
        irq_val = 8'h40;
        for (int n = 0; n < 4000 && rx_q.size() < 255; n++) tick();
        repeat (40) tick();
        total++;
        if (rx_q.size() != 255 || fifo_q.size() != 0) begin
            bad++; $display("FAIL len255_count: got %0d bytes %0d unread required 255 and 0", rx_q.size(), fifo_q.size());
        end else begin
            data_errs = 0;
            last_cnt = 0;
            for (int i = 0; i < 255; i++) begin
                if (rx_q[i] !== 8'(i)) data_errs++;
                if (rx_last_q[i]) last_cnt++;
            end
            total++;
            if (data_errs != 0 || last_cnt != 1 || rx_last_q[254] !== 1'b1) begin
                bad++; $display("FAIL len255_data: got %0d data errors, %0d last flags, final last=%b required 0,1,1", data_errs, last_cnt, rx_last_q[254]);
            end
        end
        total++;
        if (pkt_len !== 8'd255) begin
            bad++; $display("FAIL len255_pkt_len: got %0d required 255", pkt_len);
        end
    endtask

    task automatic test_disable();
        int sz;
        rx_q.delete(); rx_last_q.delete();
        len_val = 8'd4; cur_val = 8'h30;
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        irq_val = 8'h40;
        for (int n = 0; n < 300 && !rx_valid; n++) tick();
        enable = 1'b0;
        for (int n = 0; n < 600 && busy; n++) tick();
        repeat (3) tick();
        total++;
        if (rx_q.size() != 4) begin
            bad++; $display("FAIL dis_count: got %0d bytes required 4", rx_q.size());
        end
        sz = log_addr.size();
        total++;
        if ({log_addr[sz-2], log_addr[sz-1], log_wdata[sz-1]} !== 24'h008181) begin
            bad++; $display("FAIL dis_stop: got %h then %h/%h required 00 then 81/81", log_addr[sz-2], log_addr[sz-1], log_wdata[sz-1]);
        end
        total++;
        if ({busy, state, spi_req} !== 6'h0) begin
            bad++; $display("FAIL dis_idle: got busy=%b state=%0d req=%b required 0", busy, state, spi_req);
        end
    endtask

    task automatic test_rst_mid();
        int s;
        rx_q.delete(); rx_last_q.delete();
        len_val = 8'd3; cur_val = 8'h10;
        fifo_q = '{8'h55, 8'h66, 8'h77};
        irq_val = 8'h40;
        enable = 1'b1;
        for (int n = 0; n < 600 && !(spi_req && state == 4'd10); n++) tick();
        total++;
        if (!(spi_req && state == 4'd10)) begin
            bad++; $display("FAIL rst_reach: got req=%b state=%0d required 1/10", spi_req, state);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({spi_req, spi_addr, spi_wdata} !== 17'h0) begin
            bad++; $display("FAIL rst_mid_spi: got req=%b addr=%h wdata=%h required all 0", spi_req, spi_addr, spi_wdata);
        end
        total++;
        if ({rx_valid, rx_data, rx_last, crc_err, pkt_len, busy, state} !== 24'h0) begin
            bad++; $display("FAIL rst_mid_out: got valid=%b data=%h last=%b crc=%b len=%h busy=%b state=%0d required 0",
                            rx_valid, rx_data, rx_last, crc_err, pkt_len, busy, state);
        end
        fifo_q.delete();
        irq_val = 8'h00;
        repeat (3) tick();
        s = log_addr.size();
        rst = 1'b1;
        for (int n = 0; n < 100 && log_addr.size() < s + 2; n++) tick();
        total++;
        if (log_addr.size() < s + 2) begin
            bad++; $display("FAIL rst_restart_timeout: got %0d txns required 2", log_addr.size() - s);
        end else if ({log_addr[s], log_wdata[s], log_addr[s+1], log_wdata[s+1]} !== 32'h81818F00) begin
            bad++; $display("FAIL rst_restart: got %h/%h %h/%h required 81/81 8f/00", log_addr[s], log_wdata[s], log_addr[s+1], log_wdata[s+1]);
        end
        total++;
        if (gap_errs != 0 || stable_errs != 0) begin
            bad++; $display("FAIL spi_protocol: got %0d gap and %0d stability errors required 0", gap_errs, stable_errs);
        end
    endtask

    initial begin
        test_reset();
        rst = 1'b1;
        test_config();
        test_packet();
        test_crc();
        test_zero_len();
        test_backpressure();
        test_len255();
        test_disable();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
